// File: rtl/mod_addsub_arb_if.sv
// ----------------------------------------------------------------------------
// mod_addsub_arb_if
// Purpose : bundles the requester, shared-unit and response signals of the
//           two-requester modular add/sub arbiter.
// Signals : req0_*/req1_*   requester handshake (valid/ready) and operation
//           opM             modulus shared by all requesters
//           u_*             operands to / result from the shared modular unit
//           resp_*          response handshake back to the requesters
// Modports: slave  - the arbiter side
//           master - the requester / shared-unit environment side
// ----------------------------------------------------------------------------
interface mod_addsub_arb_if #(
    parameter int unsigned WIDTH = 256
);
    // requester 0
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_sub;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    // requester 1
    logic             req1_valid;
    logic             req1_ready;
    logic             req1_sub;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    // shared modulus
    logic [WIDTH-1:0] opM;

    // shared modular unit
    logic [WIDTH-1:0] u_opA;
    logic [WIDTH-1:0] u_opB;
    logic [WIDTH-1:0] u_opM;
    logic             u_sub;
    logic [WIDTH-1:0] u_result;

    // response channel
    logic             resp_valid;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;
    logic             resp_ready;

    modport slave (
        input  req0_valid, req0_sub, req0_a, req0_b,
        input  req1_valid, req1_sub, req1_a, req1_b,
        input  opM, u_result, resp_ready,
        output req0_ready, req1_ready,
        output u_opA, u_opB, u_opM, u_sub,
        output resp_valid, resp_id, resp_data
    );

    modport master (
        output req0_valid, req0_sub, req0_a, req0_b,
        output req1_valid, req1_sub, req1_a, req1_b,
        output opM, u_result, resp_ready,
        input  req0_ready, req1_ready,
        input  u_opA, u_opB, u_opM, u_sub,
        input  resp_valid, resp_id, resp_data
    );
endinterface

// File: rtl/mod_addsub_arb.sv
// ----------------------------------------------------------------------------
// mod_addsub_arb
// Purpose : arbitrates two requesters onto one shared modular add/sub unit.
//           One operation is in flight at a time: IDLE accepts, BUSY holds the
//           operands on the unit for LAT cycles, RESP presents the result
//           until the consumer takes it. The arbiter does no arithmetic.
// Params  : WIDTH - operand/modulus width in bits
//           LAT   - shared unit latency in cycles (1..4)
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - mod_addsub_arb_if.slave (requesters, unit, response)
// Config  : MODARB_FIXED_PRIO_EN - when defined requester 0 always wins a tie;
//           otherwise ties alternate round-robin.
// Notes   : reqN_ready is decoded combinationally from state and reqN_valid
//           so a requester can transfer in the same cycle it raises valid.
// ----------------------------------------------------------------------------
module mod_addsub_arb #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned LAT   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    mod_addsub_arb_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               id_q, id_d;
    logic               sub_q, sub_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               rvalid_q, rvalid_d;

    logic               gnt_c;
    logic               rdy0_c;
    logic               rdy1_c;
    logic               xfer_c;

    // Grant selection: a lone requester always wins; ties go by policy.
    always_comb begin
        gnt_c = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef MODARB_FIXED_PRIO_EN
            gnt_c = 1'b0;
`else
            gnt_c = ~last_q;
`endif
        end else if (bus.req1_valid) begin
            gnt_c = 1'b1;
        end
    end

    // Ready only in IDLE, only for the granted requester, masked during reset.
    always_comb begin
        rdy0_c = rst_n && (state_q == IDLE) && bus.req0_valid && !gnt_c;
        rdy1_c = rst_n && (state_q == IDLE) && bus.req1_valid &&  gnt_c;
        xfer_c = rdy0_c || rdy1_c;
    end

    // Next-state and datapath register loads.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        id_d     = id_q;
        sub_d    = sub_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        data_d   = data_q;
        rvalid_d = rvalid_q;

        case (state_q)
            IDLE: begin
                if (xfer_c) begin
                    id_d    = gnt_c;
                    last_d  = gnt_c;
                    sub_d   = gnt_c ? bus.req1_sub : bus.req0_sub;
                    a_d     = gnt_c ? bus.req1_a   : bus.req0_a;
                    b_d     = gnt_c ? bus.req1_b   : bus.req0_b;
                    m_d     = bus.opM;
                    cnt_d   = CNT_W'(LAT);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // The decrement that lands on zero is the capture cycle.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    data_d   = bus.u_result;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                rvalid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            sub_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            data_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            id_q     <= id_d;
            sub_q    <= sub_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            data_q   <= data_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Operands only change on a transfer, so they are stable through BUSY.
    assign bus.u_opA      = a_q;
    assign bus.u_opB      = b_q;
    assign bus.u_opM      = m_q;
    assign bus.u_sub      = sub_q;

    assign bus.req0_ready = rdy0_c;
    assign bus.req1_ready = rdy1_c;

    assign bus.resp_valid = rvalid_q;
    assign bus.resp_id    = id_q;
    assign bus.resp_data  = data_q;

endmodule

// File: tb/tb_mod_addsub_arb.sv
// ----------------------------------------------------------------------------
// tb_mod_addsub_arb
// Self-checking bench for mod_addsub_arb (LAT=3). Contains a pipelined model
// of the shared modular unit and a reference model for results and grants.
// Honours MODARB_FIXED_PRIO_EN for the tie-break expectation.
// ----------------------------------------------------------------------------
module tb_mod_addsub_arb;
    localparam int unsigned W   = 256;
    localparam int unsigned LAT = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   model_last;

    mod_addsub_arb_if #(.WIDTH(W)) bus ();

    mod_addsub_arb #(.WIDTH(W), .LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Spec-level modular add/sub.
    function automatic logic [W-1:0] modop(input logic sub, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] m);
        logic [W:0] s;
        if (m == '0) return '0;
        s = sub ? ({1'b0, a} + {1'b0, m} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        return W'(s % {1'b0, m});
    endfunction

    // Shared unit: LAT=3 -> result reflects operands seen two edges earlier.
    logic [W-1:0] u_s1, u_s2;
    always @(posedge clk) begin
        u_s1 <= modop(bus.u_sub, bus.u_opA, bus.u_opB, bus.u_opM);
        u_s2 <= u_s1;
    end
    assign bus.u_result = u_s2;

    function automatic logic [W-1:0] rnd256();
        logic [W-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int exp_tie();
`ifdef MODARB_FIXED_PRIO_EN
        return 0;
`else
        return 1 - model_last;
`endif
    endfunction

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One operation from a single requester, checking exact timing.
    task automatic single_op(input logic id, input logic sub, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] m,
                             input logic [W-1:0] exp, input string nm);
        @(negedge clk);
        bus.opM = m;
        if (id) begin
            bus.req1_sub = sub; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_sub = sub; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
        end
        #1;
        check({nm, " ready"}, W'(id ? bus.req1_ready : bus.req0_ready), W'(1));
        check({nm, " other_ready"}, W'(id ? bus.req0_ready : bus.req1_ready), W'(0));
        @(posedge clk);
        model_last = int'(id);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check({nm, " busy_resp_valid"}, W'(bus.resp_valid), W'(0));
            check({nm, " busy_u_sub"}, W'(bus.u_sub), W'(sub));
            check({nm, " busy_u_opA"}, bus.u_opA, a);
            check({nm, " busy_ready"}, W'(id ? bus.req1_ready : bus.req0_ready), W'(0));
        end
        @(negedge clk);
        check({nm, " resp_valid"}, W'(bus.resp_valid), W'(1));
        check({nm, " resp_id"}, W'(bus.resp_id), W'(id));
        check({nm, " resp_data"}, bus.resp_data, exp);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        check({nm, " resp_done"}, W'(bus.resp_valid), W'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
    endtask

    typedef struct {
        logic         id;
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] m;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] m, a, b;
        logic         sub, id, saw;
        int           gid[4];
        int           gcyc[4];
        int           rid[4];
        logic [W-1:0] rdata[4];
        int           ng, nr, e, cnt;

        checks = 0; failures = 0; model_last = 1;
        ones = '1;
        vt[0] = '{1'b0, 1'b0, W'(50), W'(60), W'(97), W'(13)};
        vt[1] = '{1'b1, 1'b1, W'(10), W'(20), W'(97), W'(87)};
        vt[2] = '{1'b0, 1'b0, W'(96), W'(96), W'(97), W'(95)};
        vt[3] = '{1'b1, 1'b1, W'(5),  W'(5),  W'(97), W'(0)};
        vt[4] = '{1'b0, 1'b0, ones - W'(1), ones - W'(1), ones, ones - W'(2)};
        vt[5] = '{1'b1, 1'b1, W'(0),  ones - W'(1), ones, W'(1)};

        rst_n = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_sub = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b1; bus.req1_sub = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.opM = W'(97); bus.resp_ready = 1'b1;

        // Reset values, with both requesters asserting valid.
        #12;
        check("rst req0_ready", W'(bus.req0_ready), W'(0));
        check("rst req1_ready", W'(bus.req1_ready), W'(0));
        check("rst resp_valid", W'(bus.resp_valid), W'(0));
        check("rst resp_id", W'(bus.resp_id), W'(0));
        check("rst resp_data", bus.resp_data, W'(0));
        check("rst u_opA", bus.u_opA, W'(0));
        check("rst u_opB", bus.u_opB, W'(0));
        check("rst u_opM", bus.u_opM, W'(0));
        check("rst u_sub", W'(bus.u_sub), W'(0));
        @(negedge clk);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        rst_n = 1'b1;

        // Directed vectors.
        foreach (vt[i])
            single_op(vt[i].id, vt[i].sub, vt[i].a, vt[i].b, vt[i].m, vt[i].exp,
                      $sformatf("vec%0d", i));

        // Randomized single-requester operations.
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                m = rnd256();
                m[W-1] = 1'b1;
            end else begin
                m = W'($urandom_range(2, 1000));
            end
            a   = rnd256() % m;
            b   = rnd256() % m;
            sub = 1'($urandom_range(0, 1));
            id  = 1'($urandom_range(0, 1));
            single_op(id, sub, a, b, m, modop(sub, a, b, m), $sformatf("rand%0d", i));
        end

        // Both requesters valid continuously: grant order and throughput.
        do_reset();
        @(negedge clk);
        bus.opM = W'(97);
        bus.req0_sub = 1'b0; bus.req0_a = W'(1); bus.req0_b = W'(2);
        bus.req1_sub = 1'b1; bus.req1_a = W'(9); bus.req1_b = W'(4);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.resp_ready = 1'b1;
        ng = 0; nr = 0;
        for (int cyc = 0; cyc < 200 && nr < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (bus.resp_valid) begin
                rid[nr] = int'(bus.resp_id); rdata[nr] = bus.resp_data; nr++;
            end
            if (ng < 4 && (bus.req0_ready || bus.req1_ready)) begin
                gid[ng] = int'(bus.req1_ready); gcyc[ng] = cyc; ng++;
                if (ng == 4) begin
                    @(posedge clk); #1;
                    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
                end
            end
        end
        check("rr grant_count", W'(ng), W'(4));
        check("rr resp_count", W'(nr), W'(4));
        for (int i = 0; i < ng; i++) begin
            e = exp_tie();
            check($sformatf("rr grant%0d", i), W'(gid[i]), W'(e));
            if (i < nr) begin
                check($sformatf("rr resp_id%0d", i), W'(rid[i]), W'(e));
                check($sformatf("rr resp_data%0d", i), rdata[i],
                      (e == 1) ? modop(1'b1, W'(9), W'(4), W'(97)) : modop(1'b0, W'(1), W'(2), W'(97)));
            end
            if (i > 0) check($sformatf("rr period%0d", i), W'(gcyc[i] - gcyc[i-1]), W'(LAT + 2));
            model_last = e;
        end

        // Response back-pressure: outputs hold, no new grant.
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req0_sub = 1'b0; bus.req0_a = W'(70); bus.req0_b = W'(40); bus.opM = W'(97);
        bus.req0_valid = 1'b1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        model_last = 0;
        cnt = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            cnt++;
            if (bus.resp_valid) break;
        end
        check("hold latency", W'(cnt), W'(LAT + 1));
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("hold%0d resp_valid", i), W'(bus.resp_valid), W'(1));
            check($sformatf("hold%0d resp_data", i), bus.resp_data, W'(13));
            check($sformatf("hold%0d readys", i), W'({bus.req0_ready, bus.req1_ready}), W'(0));
            @(negedge clk);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("hold released", W'(bus.resp_valid), W'(0));
        check("hold no_new_grant", bus.u_opA, W'(70));

        // Reset in the middle of BUSY.
        bus.opM = W'(97);
        bus.req1_sub = 1'b1; bus.req1_a = W'(10); bus.req1_b = W'(20);
        bus.req1_valid = 1'b1;
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        model_last = 1;
        @(negedge clk);
        check("midrst pre u_sub", W'(bus.u_sub), W'(1));
        #2 rst_n = 1'b0;
        #1;
        check("midrst resp_valid", W'(bus.resp_valid), W'(0));
        check("midrst resp_id", W'(bus.resp_id), W'(0));
        check("midrst resp_data", bus.resp_data, W'(0));
        check("midrst u_opA", bus.u_opA, W'(0));
        check("midrst u_opM", bus.u_opM, W'(0));
        check("midrst u_sub", W'(bus.u_sub), W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
        saw = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (bus.resp_valid) saw = 1'b1;
        end
        check("midrst no_resp", W'(saw), W'(0));

        // First tie after reset.
        bus.req0_sub = 1'b0; bus.req0_a = W'(50); bus.req0_b = W'(60);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        #1;
        e = exp_tie();
        check("tie req0_ready", W'(bus.req0_ready), W'(e == 0));
        check("tie req1_ready", W'(bus.req1_ready), W'(e == 1));
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        model_last = e;
        saw = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus.resp_valid) begin saw = 1'b1; break; end
        end
        check("tie resp_seen", W'(saw), W'(1));
        check("tie resp_id", W'(bus.resp_id), W'(e));
        check("tie resp_data", bus.resp_data, W'(13));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod_addsub_arb.md
MOD_ADDSUB_ARB -- requirements
Module: mod_addsub_arb

Interface
REQ-001 SHALL have parameter: WIDTH, 256, operand/modulus width in bits.
REQ-002 SHALL have parameter: LAT, 1, shared modular unit latency in clock cycles (1..4), operands to result.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: reqN_valid  input  1  requester N (N=0,1) has an operation pending.
REQ-006 SHALL have ports: reqN_ready  output  1  arbiter accepts requester N operation this cycle.
REQ-007 SHALL have ports: reqN_sub  input  1  requester N operation select: 0 = add, 1 = subtract.
REQ-008 SHALL have ports: reqN_a, reqN_b  input  WIDTH  requester N operands, each < opM.
REQ-009 SHALL have port: opM  input  WIDTH  modulus shared by all requesters, stable while busy.
REQ-010 SHALL have ports: u_opA, u_opB, u_opM  output  WIDTH  operands driven to the shared modular add/sub unit.
REQ-011 SHALL have port: u_sub  output  1  selects subMod (1) or addMod (0) result path.
REQ-012 SHALL have port: u_result  input  WIDTH  shared unit result, valid LAT cycles after operand launch.
REQ-013 SHALL have ports: resp_valid  output  1; resp_id  output  1; resp_data  output  WIDTH; resp_ready  input  1.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-015 In IDLE, reqN_ready SHALL be 1 only for the granted requester and only when its reqN_valid is 1; transfer occurs when valid and ready are both 1.
REQ-016 On transfer, SHALL latch a, b, sub and requester id into internal registers, load a latency counter with LAT, and move to BUSY.
REQ-017 u_opA/u_opB/u_sub/u_opM SHALL be driven from the latched registers and held stable for the whole of BUSY.
REQ-018 In BUSY the counter SHALL decrement each cycle; when it reaches 0, u_result SHALL be captured into resp_data and the FSM moves to RESP.
REQ-019 In RESP, resp_valid SHALL be 1 and resp_id/resp_data stable until resp_ready is 1; then IDLE on the next edge.
REQ-020 Accept-to-resp_valid latency SHALL be exactly LAT+1 cycles; back-to-back throughput is one operation per LAT+2 cycles with resp_ready held 1.
REQ-021 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-022 The last-grant pointer SHALL update only on a transfer.
REQ-023 reqN_ready SHALL be 0 in BUSY and RESP; a requester dropping valid before transfer SHALL cause no state change.
REQ-024 The arbiter SHALL perform no arithmetic; modular reduction is entirely the shared unit's responsibility.

Reset
REQ-025 On rst_n = 0 the FSM SHALL enter IDLE immediately, independent of clk.
REQ-026 Reset values: resp_valid 0, resp_id 0, resp_data 0, reqN_ready 0, u_opA/u_opB/u_opM 0, u_sub 0, counter 0, last-grant pointer = 1 (requester 0 wins first tie).
REQ-027 Reset asserted during BUSY or RESP SHALL discard the in-flight operation; no response is produced after release.

Configuration
REQ-028 Macro MODARB_FIXED_PRIO_EN: when defined, requester 0 SHALL always win when both are valid and the pointer is unused; when undefined, REQ-021 round-robin applies.

Verification
REQ-029 opM=97, req0 add a=50 b=60 -> resp_valid after LAT+1 cycles, resp_id=0, resp_data=13.
REQ-030 opM=97, req1 sub a=10 b=20 -> resp_id=1, resp_data=87; u_sub=1 throughout BUSY.
REQ-031 Both valid continuously, resp_ready=1, 4 ops -> grant order 0,1,0,1 (without macro); 0,0,0,0 with MODARB_FIXED_PRIO_EN.
REQ-032 resp_ready held 0 for 5 cycles in RESP -> resp_valid/resp_data stable, both reqN_ready 0, no new grant.
REQ-033 rst_n pulsed low mid-BUSY -> all outputs at reset values immediately, no resp_valid afterwards, next tie granted to requester 0.
REQ-034 LAT=3, opM=97, a=96 b=96 add -> resp_data=95 exactly 4 cycles after transfer.
